// File: rtl/pt_walk_pkg.sv
// Shared widths, PTE bit positions and walker state encoding.
// PT_WALK_WB_EN adds the victim writeback states to the enum.
package pt_walk_pkg;

    localparam int unsigned VPN_W     = 8;
    localparam int unsigned PPN_W     = 6;
    localparam int unsigned PTE_W     = 9;

    localparam int unsigned PTE_VALID = 8;
    localparam int unsigned PTE_DIRTY = 7;
    localparam int unsigned PTE_REF   = 6;

    typedef enum logic [2:0] {
        IDLE,
`ifdef PT_WALK_WB_EN
        WB_RD,
        WB_WR,
`endif
        RD,
        CHK,
        FILL
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pt_walker.sv
// TLB miss walker: optional victim writeback, PTE lookup with ref-bit set, fill return.
// Build option: define PT_WALK_WB_EN to include the victim dirty/ref writeback path.
module pt_walker
    import pt_walk_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned PT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_valid,
    output logic             miss_ready,
    input  logic [VPN_W-1:0] miss_vpn,
    input  logic             evict_valid,
    input  logic [VPN_W-1:0] evict_vpn,
    input  logic             evict_dirty,
    input  logic             evict_ref,
    output logic [VPN_W-1:0] pt_addr,
    output logic             pt_rd,
    output logic             pt_wr,
    output logic [PTE_W-1:0] pt_wdata,
    input  logic [PTE_W-1:0] pt_rdata,
    output logic             fill_valid,
    input  logic             fill_ready,
    output logic [VPN_W-1:0] fill_vpn,
    output logic [PPN_W-1:0] fill_ppn,
    output logic             fill_fault,
    output logic             busy,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] fault_count
);

    if (PT_LAT != 1) begin : g_lat_check
        $error("pt_walker: only PT_LAT=1 is supported");
    end

    state_t           state;
    logic [VPN_W-1:0] vpn_q;
    logic             accept;
    logic             fault_inc;

`ifdef PT_WALK_WB_EN
    logic [VPN_W-1:0] ev_vpn_q;
    logic             ev_dirty_q;
    logic             ev_ref_q;
`else
    logic             unused_evict;
    assign unused_evict = ^{evict_valid, evict_vpn, evict_dirty, evict_ref};
`endif

    assign accept    = (state == IDLE) && miss_valid && miss_ready;
    assign fault_inc = (state == CHK) && !pt_rdata[PTE_VALID];

    // Page-table side follows read data in the same cycle, so it decodes from state.
    always_comb begin
        pt_rd    = 1'b0;
        pt_wr    = 1'b0;
        pt_addr  = '0;
        pt_wdata = '0;
        case (state)
`ifdef PT_WALK_WB_EN
            WB_RD: begin
                pt_rd   = 1'b1;
                pt_addr = ev_vpn_q;
            end
            WB_WR: begin
                pt_wr               = 1'b1;
                pt_addr             = ev_vpn_q;
                pt_wdata            = pt_rdata;
                pt_wdata[PTE_DIRTY] = pt_rdata[PTE_DIRTY] | ev_dirty_q;
                pt_wdata[PTE_REF]   = pt_rdata[PTE_REF] | ev_ref_q;
            end
`endif
            RD: begin
                pt_rd   = 1'b1;
                pt_addr = vpn_q;
            end
            CHK: begin
                if (pt_rdata[PTE_VALID]) begin
                    pt_wr             = 1'b1;
                    pt_addr           = vpn_q;
                    pt_wdata          = pt_rdata;
                    pt_wdata[PTE_REF] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vpn_q      <= '0;
            miss_ready <= 1'b0;
            busy       <= 1'b0;
            fill_valid <= 1'b0;
            fill_vpn   <= '0;
            fill_ppn   <= '0;
            fill_fault <= 1'b0;
`ifdef PT_WALK_WB_EN
            ev_vpn_q   <= '0;
            ev_dirty_q <= 1'b0;
            ev_ref_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    miss_ready <= 1'b1;
                    if (accept) begin
                        vpn_q      <= miss_vpn;
                        miss_ready <= 1'b0;
                        busy       <= 1'b1;
`ifdef PT_WALK_WB_EN
                        ev_vpn_q   <= evict_vpn;
                        ev_dirty_q <= evict_dirty;
                        ev_ref_q   <= evict_ref;
                        state      <= (evict_valid && (evict_dirty || evict_ref)) ? WB_RD : RD;
`else
                        state      <= RD;
`endif
                    end
                end
`ifdef PT_WALK_WB_EN
                WB_RD: state <= WB_WR;
                WB_WR: state <= RD;
`endif
                RD: state <= CHK;
                CHK: begin
                    fill_valid <= 1'b1;
                    fill_vpn   <= vpn_q;
                    fill_ppn   <= pt_rdata[PTE_VALID] ? pt_rdata[PPN_W-1:0] : '0;
                    fill_fault <= !pt_rdata[PTE_VALID];
                    state      <= FILL;
                end
                FILL: begin
                    if (fill_ready) begin
                        fill_valid <= 1'b0;
                        fill_vpn   <= '0;
                        fill_ppn   <= '0;
                        fill_fault <= 1'b0;
                        busy       <= 1'b0;
                        miss_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .count (miss_count)
    );

    sat_counter #(.W(CNT_W)) u_fault_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fault_inc),
        .count (fault_count)
    );

endmodule

// File: tb/tb_pt_walker.sv
// Directed bench for pt_walker with a 1-cycle page-table memory model and write log.
// Expectations follow PT_WALK_WB_EN when the bench is built with the same define.
module tb_pt_walker;

    logic       clk = 1'b0;
    logic       rst;
    logic       miss_valid;
    logic       miss_ready;
    logic [7:0] miss_vpn;
    logic       evict_valid;
    logic [7:0] evict_vpn;
    logic       evict_dirty;
    logic       evict_ref;
    logic [7:0] pt_addr;
    logic       pt_rd;
    logic       pt_wr;
    logic [8:0] pt_wdata;
    logic [8:0] pt_rdata;
    logic       fill_valid;
    logic       fill_ready;
    logic [7:0] fill_vpn;
    logic [5:0] fill_ppn;
    logic       fill_fault;
    logic       busy;
    logic [1:0] miss_count;
    logic [1:0] fault_count;

    int errors = 0;
    int checks = 0;
    int both_cnt = 0;
    int base;

    logic [8:0] pt_mem [256];
    logic [7:0] wr_addr [$];
    logic [8:0] wr_data [$];

    always #5 clk = ~clk;

    pt_walker #(.CNT_W(2), .PT_LAT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .miss_valid  (miss_valid),
        .miss_ready  (miss_ready),
        .miss_vpn    (miss_vpn),
        .evict_valid (evict_valid),
        .evict_vpn   (evict_vpn),
        .evict_dirty (evict_dirty),
        .evict_ref   (evict_ref),
        .pt_addr     (pt_addr),
        .pt_rd       (pt_rd),
        .pt_wr       (pt_wr),
        .pt_wdata    (pt_wdata),
        .pt_rdata    (pt_rdata),
        .fill_valid  (fill_valid),
        .fill_ready  (fill_ready),
        .fill_vpn    (fill_vpn),
        .fill_ppn    (fill_ppn),
        .fill_fault  (fill_fault),
        .busy        (busy),
        .miss_count  (miss_count),
        .fault_count (fault_count)
    );

    // Page table: reloaded under reset, read data one cycle after pt_rd, writes logged.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) pt_mem[i] <= 9'h000;
            pt_mem[8'h12] <= 9'h14B;
            pt_mem[8'h30] <= 9'h005;
            pt_mem[8'h40] <= 9'h107;
            pt_mem[8'h41] <= 9'h103;
            pt_mem[8'h22] <= 9'h101;
            pt_rdata      <= 9'h000;
        end else begin
            if (pt_rd) pt_rdata <= pt_mem[pt_addr];
            if (pt_wr) begin
                pt_mem[pt_addr] <= pt_wdata;
                wr_addr.push_back(pt_addr);
                wr_data.push_back(pt_wdata);
            end
            if (pt_rd && pt_wr) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_miss(input logic [7:0] vpn, input logic ev, input logic [7:0] evpn,
                            input logic ed, input logic er, input int hold,
                            input logic [5:0] exp_ppn, input logic exp_fault);
        int   n;
        int   exp_lat;
        logic wb;
`ifdef PT_WALK_WB_EN
        wb = ev && (ed || er);
`else
        wb = 1'b0;
`endif
        exp_lat = wb ? 5 : 3;
        check("accept_ready", 32'(miss_ready), 1);
        miss_valid  = 1'b1;
        miss_vpn    = vpn;
        evict_valid = ev;
        evict_vpn   = evpn;
        evict_dirty = ed;
        evict_ref   = er;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            miss_valid  = 1'b0;
            evict_valid = 1'b0;
            evict_dirty = 1'b0;
            evict_ref   = 1'b0;
            if (n == 1) begin
                check("first_rd", 32'(pt_rd), 1);
                check("first_rd_addr", 32'(pt_addr), wb ? 32'(evpn) : 32'(vpn));
            end
        end while (!fill_valid && n < 20);
        check("fill_latency", 32'(n), 32'(exp_lat));
        check("fill_vpn", 32'(fill_vpn), 32'(vpn));
        check("fill_ppn", 32'(fill_ppn), 32'(exp_ppn));
        check("fill_fault", 32'(fill_fault), 32'(exp_fault));
        check("busy_in_fill", 32'(busy), 1);
        check("ready_in_fill", 32'(miss_ready), 0);
        for (int i = 0; i < hold; i++) begin
            miss_valid = 1'b1;
            miss_vpn   = 8'h30;
            @(negedge clk);
            check("hold_valid", 32'(fill_valid), 1);
            check("hold_vpn", 32'(fill_vpn), 32'(vpn));
            check("hold_ppn", 32'(fill_ppn), 32'(exp_ppn));
            check("hold_fault", 32'(fill_fault), 32'(exp_fault));
            check("hold_ready", 32'(miss_ready), 0);
        end
        miss_valid = 1'b0;
        fill_ready = 1'b1;
        @(negedge clk);
        fill_ready = 1'b0;
        check("idle_ready", 32'(miss_ready), 1);
        check("idle_busy", 32'(busy), 0);
        check("idle_fill_valid", 32'(fill_valid), 0);
    endtask

    initial begin
        rst = 1'b1;
        miss_valid = 1'b0; miss_vpn = 8'h00;
        evict_valid = 1'b0; evict_vpn = 8'h00; evict_dirty = 1'b0; evict_ref = 1'b0;
        fill_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_miss_ready", 32'(miss_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fill_valid", 32'(fill_valid), 0);
        check("rst_pt_rd", 32'(pt_rd), 0);
        check("rst_pt_wr", 32'(pt_wr), 0);
        check("rst_pt_addr", 32'(pt_addr), 0);
        check("rst_miss_count", 32'(miss_count), 0);
        check("rst_fault_count", 32'(fault_count), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(miss_ready), 1);

        // valid PTE with ref already set: written back unchanged
        base = wr_addr.size();
        run_miss(8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 0, 6'h0B, 1'b0);
        check("hit_wr_n", 32'(wr_addr.size() - base), 1);
        check("hit_wr_addr", 32'(wr_addr[base]), 'h12);
        check("hit_wr_data", 32'(wr_data[base]), 'h14B);
        check("hit_miss_count", 32'(miss_count), 1);
        check("hit_fault_count", 32'(fault_count), 0);

        // fill stalled 5 cycles while a second miss is offered
        base = wr_addr.size();
        run_miss(8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 5, 6'h0B, 1'b0);
        check("stall_wr_n", 32'(wr_addr.size() - base), 1);
        check("stall_miss_count", 32'(miss_count), 2);

        // invalid PTE: fault, no write
        base = wr_addr.size();
        run_miss(8'h30, 1'b0, 8'h00, 1'b0, 1'b0, 0, 6'h00, 1'b1);
        check("fault_wr_n", 32'(wr_addr.size() - base), 0);
        check("fault_miss_count", 32'(miss_count), 3);
        check("fault_fault_count", 32'(fault_count), 1);

        // dirty+ref victim 0x40, miss 0x41
        base = wr_addr.size();
        run_miss(8'h41, 1'b1, 8'h40, 1'b1, 1'b1, 0, 6'h03, 1'b0);
`ifdef PT_WALK_WB_EN
        check("wb_wr_n", 32'(wr_addr.size() - base), 2);
        check("wb_wr0_addr", 32'(wr_addr[base]), 'h40);
        check("wb_wr0_data", 32'(wr_data[base]), 'h1C7);
        check("wb_wr1_addr", 32'(wr_addr[base+1]), 'h41);
        check("wb_wr1_data", 32'(wr_data[base+1]), 'h143);
        check("wb_mem40", 32'(pt_mem[8'h40]), 'h1C7);
`else
        check("wb_wr_n", 32'(wr_addr.size() - base), 1);
        check("wb_wr0_addr", 32'(wr_addr[base]), 'h41);
        check("wb_wr0_data", 32'(wr_data[base]), 'h143);
        check("wb_mem40", 32'(pt_mem[8'h40]), 'h107);
`endif
        check("sat_miss_count", 32'(miss_count), 3);

        // victim and miss share vpn 0x22
        base = wr_addr.size();
        run_miss(8'h22, 1'b1, 8'h22, 1'b1, 1'b0, 0, 6'h01, 1'b0);
`ifdef PT_WALK_WB_EN
        check("same_wr_n", 32'(wr_addr.size() - base), 2);
        check("same_wr0_data", 32'(wr_data[base]), 'h181);
        check("same_wr1_data", 32'(wr_data[base+1]), 'h1C1);
        check("same_mem22", 32'(pt_mem[8'h22]), 'h1C1);
`else
        check("same_wr_n", 32'(wr_addr.size() - base), 1);
        check("same_wr0_data", 32'(wr_data[base]), 'h141);
        check("same_mem22", 32'(pt_mem[8'h22]), 'h141);
`endif

        // clean victim: no writeback in either build
        base = wr_addr.size();
        run_miss(8'h12, 1'b1, 8'h12, 1'b0, 1'b0, 0, 6'h0B, 1'b0);
        check("clean_wr_n", 32'(wr_addr.size() - base), 1);
        check("clean_wr_addr", 32'(wr_addr[base]), 'h12);

        // reset asserted during CHK
        check("pre_rst_ready", 32'(miss_ready), 1);
        miss_valid = 1'b1;
        miss_vpn   = 8'h41;
        @(negedge clk);
        miss_valid = 1'b0;
        @(negedge clk);
        check("chk_pt_wr", 32'(pt_wr), 1);
        check("chk_pt_addr", 32'(pt_addr), 'h41);
        base = wr_addr.size();
        rst = 1'b1;
        #1;
        check("abort_pt_wr", 32'(pt_wr), 0);
        check("abort_pt_addr", 32'(pt_addr), 0);
        check("abort_pt_wdata", 32'(pt_wdata), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_miss_ready", 32'(miss_ready), 0);
        check("abort_fill_valid", 32'(fill_valid), 0);
        check("abort_miss_count", 32'(miss_count), 0);
        check("abort_fault_count", 32'(fault_count), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_write", 32'(wr_addr.size() - base), 0);
        check("abort_fill_after", 32'(fill_valid), 0);

        // repeated faults saturate the fault counter
        for (int i = 0; i < 4; i++) begin
            run_miss(8'h30, 1'b0, 8'h00, 1'b0, 1'b0, 0, 6'h00, 1'b1);
            check("loop_fault_count", 32'(fault_count), (i < 3) ? 32'(i + 1) : 3);
            check("loop_miss_count", 32'(miss_count), (i < 3) ? 32'(i + 1) : 3);
        end

        check("rd_wr_overlap", 32'(both_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
